// File: rtl/rsqrtf_arbiter.sv
// rsqrtf_arbiter: shares one iterative float32 reciprocal-square-root unit
// among N requesters. Requests are granted round-robin, the owner of the single
// in-flight operation is remembered so its result can be routed back through a
// valid/ready register stage, and lost or unexpected results raise a sticky err.
module rsqrtf_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*32-1:0] req_x,
  input  logic [N-1:0]    req_vld,
  output logic [N-1:0]    req_rdy,
  output logic [31:0]     rs_x,
  output logic            rs_xvld,
  input  logic            rs_xrdy,
  input  logic [31:0]     rs_r,
  input  logic            rs_rvld,
  output logic [31:0]     res_r,
  output logic [N-1:0]    res_dst,
  output logic            res_vld,
  input  logic            res_rdy,
  output logic            err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // The timeout decision is taken one cycle before err becomes visible, so that
  // err rises exactly TIMEOUT cycles after the issue handshake.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_e;

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] owner_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rs_x_q;
  logic [31:0]   res_r_q;
  logic [N-1:0]  res_dst_q;
  logic          res_vld_q;
  logic          err_q;

  logic          grant_vld;
  logic [PW-1:0] grant_d;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] scan_idx;
  logic [31:0]   grant_x;

  // Cyclic scan starting at ptr; the first requester found with req_vld wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_d   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req_vld[scan_idx]) begin
        grant_vld = 1'b1;
        grant_d   = scan_idx;
      end
      scan_idx = (scan_idx == PW'(N - 1)) ? '0 : scan_idx + PW'(1);
    end
  end

  // Operand of the granted requester and the pointer position just past it.
  always_comb begin
    grant_x = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_d == PW'(i)) begin
        grant_x = req_x[i*32 +: 32];
      end
    end
    ptr_d = (grant_d == PW'(N - 1)) ? '0 : grant_d + PW'(1);
  end

  // Main controller: grant, issue, wait for the result, hold it until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      rs_x_q    <= '0;
      res_r_q   <= '0;
      res_dst_q <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (rs_rvld && (state_q != WAIT)) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (grant_vld) begin
            rs_x_q  <= grant_x;
            owner_q <= grant_d;
            ptr_q   <= ptr_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (rs_xrdy) begin
            cnt_q   <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (rs_rvld) begin
            res_r_q   <= rs_r;
            res_dst_q <= N'(1) << owner_q;
            res_vld_q <= 1'b1;
            state_q   <= HOLD;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HOLD: begin
          if (res_rdy) begin
            res_vld_q <= 1'b0;
            res_dst_q <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy = ((state_q == IDLE) && grant_vld) ? (N'(1) << grant_d) : '0;
  assign rs_x    = rs_x_q;
  assign rs_xvld = (state_q == ISSUE);
  assign res_r   = res_r_q;
  assign res_dst = res_dst_q;
  assign res_vld = res_vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rsqrtf_arbiter.sv
// tb_rsqrtf_arbiter: directed bench for the shared rsqrt arbiter, using a
// behavioural rsqrt unit stub with fixed latency that can be silenced or made
// to emit unsolicited result pulses.
module tb_rsqrtf_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 31;
  localparam int LAT     = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*32-1:0] reqX;
  logic [N-1:0]    reqVld;
  logic [N-1:0]    reqRdy;
  logic [31:0]     rsX;
  logic            rsXvld;
  logic            rsXrdy;
  logic [31:0]     rsR;
  logic            rsRvld;
  logic [31:0]     resR;
  logic [N-1:0]    resDst;
  logic            resVld;
  logic            resRdy;
  logic            err;

  logic        stubBusy;
  logic        stubDead;
  logic        injectRvld;
  int          stubLeft;
  logic [31:0] stubX;

  int cyc         = 0;
  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int          idx;
    logic [31:0] x;
    logic [31:0] expR;
    logic [N-1:0] expDst;
  } vec_t;

  vec_t        vecs[5];
  logic [N-1:0] rrDst[4];
  logic [31:0]  rrR[4];

  rsqrtf_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_x   (reqX),
    .req_vld (reqVld),
    .req_rdy (reqRdy),
    .rs_x    (rsX),
    .rs_xvld (rsXvld),
    .rs_xrdy (rsXrdy),
    .rs_r    (rsR),
    .rs_rvld (rsRvld),
    .res_r   (resR),
    .res_dst (resDst),
    .res_vld (resVld),
    .res_rdy (resRdy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact reciprocal square root for positive powers of four; anything else
  // yields a quiet NaN, which no vector expects.
  function automatic logic [31:0] rsqrtModel(input logic [31:0] x);
    int e;
    e = int'(x[30:23]) - 127;
    if (x[22:0] == 23'd0 && x[31] == 1'b0 && (e % 2) == 0) begin
      return {1'b0, 8'(127 - e / 2), 23'd0};
    end
    return 32'h7FC00000;
  endfunction

  // Rsqrt unit stub: accepts when idle, pulses its result LAT cycles later.
  always @(posedge clk) begin
    if (rst) begin
      stubBusy <= 1'b0;
      stubLeft <= 0;
      stubX    <= '0;
    end else if (!stubBusy) begin
      if (rsXvld) begin
        stubBusy <= 1'b1;
        stubLeft <= LAT;
        stubX    <= rsX;
      end
    end else begin
      if (stubLeft == 1) begin
        stubBusy <= 1'b0;
      end
      stubLeft <= stubLeft - 1;
    end
  end

  assign rsXrdy = !stubBusy;
  assign rsRvld = (stubBusy && stubLeft == 1 && !stubDead) || injectRvld;
  assign rsR    = rsqrtModel(stubX);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for an event: 0 grant, 1 result valid, 2 issue handshake, 3 err.
  task automatic waitFor(input int sel, input string name);
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      case (sel)
        0:       hit = (reqRdy != '0);
        1:       hit = resVld;
        2:       hit = rsXvld && rsXrdy;
        default: hit = err;
      endcase
      if (hit) break;
    end
    checkOutput(name, 64'(hit), 64'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_rdy"}, 64'(reqRdy), 64'd0);
    checkOutput({tag, "_rs_xvld"}, 64'(rsXvld), 64'd0);
    checkOutput({tag, "_rs_x"}, 64'(rsX), 64'd0);
    checkOutput({tag, "_res_r"}, 64'(resR), 64'd0);
    checkOutput({tag, "_res_dst"}, 64'(resDst), 64'd0);
    checkOutput({tag, "_res_vld"}, 64'(resVld), 64'd0);
    checkOutput({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // One isolated request: single-cycle grant, operand capture, routing, latency.
  task automatic applyStimulus(input vec_t v);
    int xCyc;
    nextDrive();
    reqVld = '0;
    reqVld[v.idx] = 1'b1;
    reqX[v.idx*32 +: 32] = v.x;
    @(negedge clk);
    checkOutput("single_grant", 64'(reqRdy), 64'(v.expDst));
    nextDrive();
    reqVld = '0;
    reqX   = '1;
    @(negedge clk);
    checkOutput("single_grant_once", 64'(reqRdy), 64'd0);
    checkOutput("single_xvld", 64'(rsXvld), 64'd1);
    checkOutput("single_xop", 64'(rsX), 64'(v.x));
    xCyc = cyc;
    waitFor(1, "single_res_seen");
    checkOutput("single_dst", 64'(resDst), 64'(v.expDst));
    checkOutput("single_r", 64'(resR), 64'(v.expR));
    checkOutput("single_spacing", 64'(cyc - xCyc), 64'(LAT + 1));
    @(negedge clk);
    checkOutput("single_res_pulse", 64'(resVld), 64'd0);
    checkOutput("single_dst_clear", 64'(resDst), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int hsCyc;
    logic sawRes;

    rst        = 1'b1;
    reqVld     = '0;
    reqX       = '0;
    resRdy     = 1'b1;
    stubDead   = 1'b0;
    injectRvld = 1'b0;

    vecs[0] = '{2, 32'h40800000, 32'h3F000000, 4'b0100};
    vecs[1] = '{0, 32'h3F800000, 32'h3F800000, 4'b0001};
    vecs[2] = '{3, 32'h42800000, 32'h3E000000, 4'b1000};
    vecs[3] = '{1, 32'h41800000, 32'h3E800000, 4'b0010};
    vecs[4] = '{1, 32'h3E800000, 32'h40000000, 4'b0010};

    rrDst[0] = 4'b0001; rrDst[1] = 4'b0010; rrDst[2] = 4'b0100; rrDst[3] = 4'b1000;
    rrR[0] = 32'h3F800000; rrR[1] = 32'h3F000000; rrR[2] = 32'h3E800000; rrR[3] = 32'h3E000000;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    $display("[TB] round-robin with all requesters active");
    nextDrive();
    reqX   = {32'h42800000, 32'h41800000, 32'h40800000, 32'h3F800000};
    reqVld = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      waitFor(0, "rr_grant_seen");
      checkOutput("rr_grant", 64'(reqRdy), 64'(rrDst[k % 4]));
      if (k == 4) begin
        nextDrive();
        reqVld = '0;
      end
      waitFor(1, "rr_res_seen");
      checkOutput("rr_dst", 64'(resDst), 64'(rrDst[k % 4]));
      checkOutput("rr_r", 64'(resR), 64'(rrR[k % 4]));
    end

    $display("[TB] single-request vector table");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    $display("[TB] result backpressure");
    nextDrive();
    reqX[63:32] = 32'h41800000;
    reqVld      = 4'b0010;
    resRdy      = 1'b0;
    @(negedge clk);
    checkOutput("bp_grant", 64'(reqRdy), 64'b0010);
    nextDrive();
    reqVld     = 4'b0001;
    reqX[31:0] = 32'h3F800000;
    waitFor(1, "bp_res_seen");
    for (int n = 0; n < 40; n++) begin
      checkOutput("bp_hold", 64'({resVld, resR, resDst, reqRdy, rsXvld}),
                  64'({1'b1, 32'h3E800000, 4'b0010, 4'b0000, 1'b0}));
      @(negedge clk);
    end
    nextDrive();
    resRdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_accept_cycle", 64'({resVld, reqRdy}), 64'({1'b1, 4'b0000}));
    @(negedge clk);
    checkOutput("bp_next_grant", 64'({resVld, resDst, reqRdy}), 64'({1'b0, 4'b0000, 4'b0001}));
    nextDrive();
    reqVld = '0;
    waitFor(1, "bp_second_res_seen");
    checkOutput("bp_second_dst", 64'(resDst), 64'b0001);
    checkOutput("bp_second_r", 64'(resR), 64'h3F800000);

    $display("[TB] missing result timeout");
    stubDead = 1'b1;
    nextDrive();
    reqX[127:96] = 32'h40800000;
    reqVld       = 4'b1000;
    @(negedge clk);
    checkOutput("to_grant", 64'(reqRdy), 64'b1000);
    nextDrive();
    reqVld = '0;
    waitFor(2, "to_handshake");
    hsCyc = cyc;
    waitFor(3, "to_err_seen");
    checkOutput("to_err_delay", 64'(cyc - hsCyc), 64'(TIMEOUT));
    checkOutput("to_idle_outputs", 64'({resVld, rsXvld, reqRdy}), 64'd0);
    stubDead = 1'b0;
    applyStimulus('{0, 32'h42800000, 32'h3E000000, 4'b0001});
    checkOutput("to_err_sticky", 64'(err), 64'd1);

    $display("[TB] spurious result in IDLE");
    nextDrive();
    rst = 1'b1;
    nextDrive();
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("reset_again");
    nextDrive();
    injectRvld = 1'b1;
    nextDrive();
    injectRvld = 1'b0;
    @(negedge clk);
    checkOutput("spur_err", 64'(err), 64'd1);
    checkOutput("spur_no_res", 64'(resVld), 64'd0);

    $display("[TB] reset during WAIT");
    nextDrive();
    rst = 1'b1;
    nextDrive();
    rst = 1'b0;
    nextDrive();
    reqX[95:64] = 32'h40800000;
    reqVld      = 4'b0100;
    @(negedge clk);
    checkOutput("mid_grant", 64'(reqRdy), 64'b0100);
    nextDrive();
    reqVld = '0;
    waitFor(2, "mid_handshake");
    repeat (2) @(negedge clk);
    nextDrive();
    rst = 1'b1;
    nextDrive();
    rst = 1'b0;
    @(negedge clk);
    checkResetValues("mid_reset");
    sawRes = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (resVld) sawRes = 1'b1;
    end
    checkOutput("mid_no_res", 64'(sawRes), 64'd0);
    nextDrive();
    reqX[63:32]  = 32'h41800000;
    reqX[127:96] = 32'h42800000;
    reqVld       = 4'b1010;
    @(negedge clk);
    checkOutput("mid_ptr_reset", 64'(reqRdy), 64'b0010);
    nextDrive();
    reqVld = '0;
    waitFor(1, "mid_res_seen");
    checkOutput("mid_dst", 64'(resDst), 64'b0010);
    checkOutput("mid_r", 64'(resR), 64'h3E800000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
